// File: rtl/rf_writeback_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU (A) vs long-latency (B) writeback and
// tracks B-owed destinations in a scoreboard. Optional perf counters: define RFWB_PERF_EN.
module rf_writeback_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [4:0]        a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  output logic              stall,
  output logic              hold_a,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       pending,
  output logic              proto_err,
  output logic [31:0]       perf_b_wait,
  output logic [31:0]       perf_stall
);

  localparam int         CW  = 4;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0]     starve_cnt;
  logic [CW-1:0]     starve_next;
  logic [31:0]       pend_q;
  logic [31:0]       pend_next;
  logic              wb_src_b;
  logic              b_hs;
  logic              b_wait;
  logic              win_valid;
  logic [4:0]        win_rd;
  logic [DATA_W-1:0] win_data;
  logic              proto_hit;

  // Handshake: A has no ready and always wins; B transfers when b_valid && b_ready,
  // with b_ready = !a_valid. A waiting B must stay presented until it transfers.
  assign b_ready = !a_valid;
  assign b_hs    = b_valid && !a_valid;
  assign b_wait  = b_valid && a_valid;

  assign win_valid = a_valid || b_valid;
  assign win_rd    = a_valid ? a_rd : b_rd;
  assign win_data  = a_valid ? a_data : b_data;

  assign hold_a  = (starve_cnt == LIM);
  assign pending = pend_q;

  assign stall = ((dec_rs1 != 5'd0) && pend_q[dec_rs1]) ||
                 ((dec_rs2 != 5'd0) && pend_q[dec_rs2]) ||
                 ((dec_rd  != 5'd0) && pend_q[dec_rd]);

  always_comb begin
    starve_next = '0;
    if (b_wait) starve_next = (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Clear first so that an issue to the same register on the same edge wins.
  always_comb begin
    pend_next = pend_q;
    if (wb_en && wb_src_b) pend_next[wb_addr] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_comb begin
    proto_hit = 1'b0;
    if (a_valid && hold_a) proto_hit = 1'b1;
    if (a_valid && (a_rd != 5'd0) && pend_q[a_rd]) proto_hit = 1'b1;
    if (iss_valid && (iss_rd != 5'd0) && pend_q[iss_rd]) proto_hit = 1'b1;
    if (b_hs && (b_rd != 5'd0) && !pend_q[b_rd]) proto_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pend_q     <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_src_b   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      pend_q     <= pend_next;
      wb_en      <= win_valid && (win_rd != 5'd0);
      wb_src_b   <= b_hs;
      if (win_valid) begin
        wb_addr <= win_rd;
        wb_data <= win_data;
      end
      if (proto_hit) proto_err <= 1'b1;
    end
  end

`ifdef RFWB_PERF_EN
  logic [31:0] perf_b_wait_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_b_wait_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (b_wait) perf_b_wait_q <= perf_b_wait_q + 32'd1;
      if (stall)  perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_b_wait = perf_b_wait_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_b_wait = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Bench for rf_writeback_scheduler: directed vector table, hand-written corner sequences,
// then constrained-random traffic checked against a behavioural model.
module tb_rf_writeback_scheduler;

  localparam int LIMIT = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [4:0]    a_rd = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [4:0]    b_rd = '0;
  logic [DW-1:0] b_data = '0;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [4:0]    dec_rs1 = '0;
  logic [4:0]    dec_rs2 = '0;
  logic [4:0]    dec_rd = '0;
  logic          stall;
  logic          hold_a;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic [31:0]   pending;
  logic          proto_err;
  logic [31:0]   perf_b_wait;
  logic [31:0]   perf_stall;

  int total = 0;
  int bad   = 0;

  rf_writeback_scheduler #(.STARVE_LIMIT(LIMIT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .stall(stall), .hold_a(hold_a),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending(pending), .proto_err(proto_err),
    .perf_b_wait(perf_b_wait), .perf_stall(perf_stall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0]       m_pend;
  int              m_wait;
  bit              m_wen;
  bit              m_src_b;
  bit [4:0]        m_addr;
  bit              m_proto;
  int unsigned     m_pbw;
  int unsigned     m_pst;
  logic [36:0]     exp_q[$];
  logic [4:0]      out_q[$];

  function automatic bit m_stall();
    return m_pend[dec_rs1] || m_pend[dec_rs2] || m_pend[dec_rd];
  endfunction

  task automatic model_reset();
    m_pend = '0; m_wait = 0; m_wen = 0; m_src_b = 0; m_addr = '0;
    m_proto = 0; m_pbw = 0; m_pst = 0;
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic model_edge();
    bit hs;
    bit [31:0] np;
    hs = b_valid && !a_valid;
    if ((a_valid && m_wait == LIMIT) || (a_valid && m_pend[a_rd]) ||
        (iss_valid && m_pend[iss_rd]) || (hs && b_rd != 0 && !m_pend[b_rd]))
      m_proto = 1;
    if (b_valid && a_valid) m_pbw++;
    if (m_stall()) m_pst++;
    np = m_pend;
    if (m_wen && m_src_b) np[m_addr] = 1'b0;
    if (iss_valid) np[iss_rd] = 1'b1;
    np[0] = 1'b0;
    m_pend = np;
    m_wait = (b_valid && a_valid) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    m_wen = 0;
    m_src_b = 0;
    if (a_valid) begin
      m_wen = (a_rd != 0); m_addr = a_rd;
      if (m_wen) exp_q.push_back({a_rd, a_data});
    end else if (b_valid) begin
      m_wen = (b_rd != 0); m_addr = b_rd; m_src_b = 1;
      if (m_wen) exp_q.push_back({b_rd, b_data});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model(input bit use_model);
    logic [36:0] w;
    bit due;
    due = (exp_q.size() != 0);
    w = due ? exp_q.pop_front() : '0;
    if (!use_model) return;
    chk("b_ready", 32'(b_ready), 32'(!a_valid));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("hold_a", 32'(hold_a), 32'(m_wait == LIMIT));
    chk("pending", pending, m_pend);
    chk("proto_err", 32'(proto_err), 32'(m_proto));
    chk("wb_en", 32'(wb_en), 32'(due));
    if (due) begin
      chk("wb_addr", 32'(wb_addr), 32'(w[36:32]));
      chk("wb_data", wb_data, w[31:0]);
    end
`ifdef RFWB_PERF_EN
    chk("perf_b_wait", perf_b_wait, m_pbw);
    chk("perf_stall", perf_stall, m_pst);
`else
    chk("perf_b_wait", perf_b_wait, 32'd0);
    chk("perf_stall", perf_stall, 32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input bit use_model);
    #1;
    compare_model(use_model);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic a_valid; logic [4:0] a_rd; logic [31:0] a_data;
    logic b_valid; logic [4:0] b_rd; logic [31:0] b_data;
    logic iss_valid; logic [4:0] iss_rd;
    logic [4:0] rs1, rs2, rd;
    logic e_b_ready, e_stall, e_wb_en;
    logic [4:0] e_wb_addr; logic [31:0] e_wb_data; logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t mk(
    logic av, logic [4:0] ard, logic [31:0] ad, logic bv, logic [4:0] brd, logic [31:0] bd,
    logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
    logic ebr, logic est, logic ewe, logic [4:0] ea, logic [31:0] ed, logic [31:0] ep);
    vec_t v;
    v.a_valid = av; v.a_rd = ard; v.a_data = ad;
    v.b_valid = bv; v.b_rd = brd; v.b_data = bd;
    v.iss_valid = iv; v.iss_rd = ird;
    v.rs1 = r1; v.rs2 = r2; v.rd = r3;
    v.e_b_ready = ebr; v.e_stall = est; v.e_wb_en = ewe;
    v.e_wb_addr = ea; v.e_wb_data = ed; v.e_pend = ep;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    bit st;

    // B-only, collision, x0 handling
    tbl[0]  = mk(0,0,0,         0,0,0,            1,5, 0,0,0, 1,0,0,0,0,                 32'h0);
    tbl[1]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 1,1,0,0,0,                 32'h20);
    tbl[2]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 1,1,0,0,0,                 32'h20);
    tbl[3]  = mk(0,0,0,         1,5,32'hDEADBEEF, 0,0, 5,0,0, 1,1,0,0,0,                 32'h20);
    tbl[4]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 1,1,1,5,32'hDEADBEEF,      32'h20);
    tbl[5]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 1,0,0,0,0,                 32'h0);
    tbl[6]  = mk(0,0,0,         0,0,0,            1,7, 0,0,0, 1,0,0,0,0,                 32'h0);
    tbl[7]  = mk(1,3,32'h11,    1,7,32'h77,       0,0, 0,0,0, 0,0,0,0,0,                 32'h80);
    tbl[8]  = mk(0,0,0,         1,7,32'h77,       0,0, 0,0,0, 1,0,1,3,32'h11,            32'h80);
    tbl[9]  = mk(0,0,0,         0,0,0,            0,0, 0,0,0, 1,0,1,7,32'h77,            32'h80);
    tbl[10] = mk(0,0,0,         0,0,0,            0,0, 0,0,7, 1,0,0,0,0,                 32'h0);
    tbl[11] = mk(1,0,32'h55,    0,0,0,            1,0, 0,0,0, 0,0,0,0,0,                 32'h0);
    tbl[12] = mk(0,0,0,         0,0,0,            0,0, 0,0,0, 1,0,0,0,0,                 32'h0);

    // Reset state, checked while rst is still high
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    chk("rst_hold", 32'(hold_a), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      a_valid = tbl[i].a_valid; a_rd = tbl[i].a_rd; a_data = tbl[i].a_data;
      b_valid = tbl[i].b_valid; b_rd = tbl[i].b_rd; b_data = tbl[i].b_data;
      iss_valid = tbl[i].iss_valid; iss_rd = tbl[i].iss_rd;
      dec_rs1 = tbl[i].rs1; dec_rs2 = tbl[i].rs2; dec_rd = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].e_b_ready));
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].e_wb_en));
      if (tbl[i].e_wb_en) begin
        chk($sformatf("tbl%0d_wb_addr", i), 32'(wb_addr), 32'(tbl[i].e_wb_addr));
        chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].e_wb_data);
      end
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_proto", i), 32'(proto_err), 32'd0);
      chk($sformatf("tbl%0d_hold", i), 32'(hold_a), 32'd0);
      step(0);
    end

    // Starvation: B held off by A for LIMIT cycles
    idle(); iss_valid = 1; iss_rd = 10; step(1);
    for (int i = 0; i < LIMIT; i++) begin
      idle();
      a_valid = 1; a_rd = 5'(i + 1); a_data = $urandom;
      b_valid = 1; b_rd = 10; b_data = 32'hB0B0_0010;
      step(1);
    end
    idle(); b_valid = 1; b_rd = 10; b_data = 32'hB0B0_0010;
    #1;
    chk("starve_hold_set", 32'(hold_a), 32'd1);
    chk("starve_b_ready", 32'(b_ready), 32'd1);
    step(1);
    idle();
    #1;
    chk("starve_wb_en", 32'(wb_en), 32'd1);
    chk("starve_wb_addr", 32'(wb_addr), 32'd10);
    chk("starve_hold_clr", 32'(hold_a), 32'd0);
    step(1);
    step(1);

    // Same-edge set and clear of x9
    idle(); iss_valid = 1; iss_rd = 9; step(1);
    idle(); step(1);
    idle(); b_valid = 1; b_rd = 9; b_data = 32'h0909_0909; step(1);
    idle(); iss_valid = 1; iss_rd = 9; step(1);
    idle();
    #1;
    chk("same_edge_pend9", 32'(pending[9]), 32'd1);
    step(1);

    // Async reset between edges while a write is visible
    do_reset();
    idle(); iss_valid = 1; iss_rd = 5; step(1);
    idle(); a_valid = 1; a_rd = 5; a_data = 32'hAB; step(1);
    idle();
    #1;
    chk("pre_rst_wb_en", 32'(wb_en), 32'd1);
    chk("pre_rst_pending", pending, 32'h20);
    chk("pre_rst_proto", 32'(proto_err), 32'd1);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
    chk("mid_rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_proto", 32'(proto_err), 32'd0);
    chk("mid_rst_hold", 32'(hold_a), 32'd0);
    chk("mid_rst_perf_bw", perf_b_wait, 32'd0);
    chk("mid_rst_perf_st", perf_stall, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Constrained-random legal traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      a_valid = (m_wait != LIMIT) && ($urandom_range(0, 1) == 1);
      do a_rd = 5'($urandom_range(0, 31)); while (m_pend[a_rd]);
      a_data = $urandom;
      b_valid = (out_q.size() != 0) && ($urandom_range(0, 9) < 6);
      b_rd = b_valid ? out_q[0] : 5'($urandom_range(0, 31));
      b_data = $urandom;
      if (b_valid && !a_valid) void'(out_q.pop_front());
      dec_rs1 = 5'($urandom_range(0, 31));
      dec_rs2 = 5'($urandom_range(0, 31));
      dec_rd  = 5'($urandom_range(0, 31));
      st = m_stall();
      iss_valid = !st && (out_q.size() < 4) && ($urandom_range(0, 9) < 4);
      if (iss_valid) begin
        do iss_rd = 5'($urandom_range(0, 31)); while (m_pend[iss_rd]);
        if (iss_rd != 0) out_q.push_back(iss_rd);
      end
      step(1);
    end
    idle();
    for (int c = 0; c < 3; c++) step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
- Shares the single register-file write port between two sources: port A, the single-cycle ALU/load writeback, and port B, a long-latency unit such as MUL/DIV.
- Keeps a 32-entry scoreboard of destination registers still owed by port B. Raises a decode stall on RAW/WAW hazards against those registers.
- Sits between the execute/writeback stage and the register file. Drives the register file's write enable, address and data.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port B may wait before the scheduler forces a bubble on port A (legal range 1..15).
- DATA_W, 32: writeback data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  ALU writeback request. Has no ready; can never be refused.
- a_rd  in  5  port A destination register.
- a_data  in  DATA_W  port A write data.
- b_valid  in  1  long-latency result valid.
- b_ready  out  1  port B accepted this cycle.
- b_rd  in  5  port B destination register.
- b_data  in  DATA_W  port B write data.
- iss_valid  in  1  a long-latency op is issued this cycle.
- iss_rd  in  5  destination register of the issued op.
- dec_rs1  in  5  source register 1 of the instruction in decode.
- dec_rs2  in  5  source register 2 of the instruction in decode.
- dec_rd  in  5  destination register of the instruction in decode.
- stall  out  1  decode must hold.
- hold_a  out  1  core must not present a_valid next cycle.
- wb_en  out  1  register-file write enable.
- wb_addr  out  5  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- pending  out  32  scoreboard contents; bit 0 is always 0.
- proto_err  out  1  sticky protocol-violation flag.
- perf_b_wait  out  32  performance counter (see Optional Feature).
- perf_stall  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (async):
  - Clears scoreboard, starvation counter, wb_en, wb_addr, wb_data, hold_a, proto_err and perf counters to 0.
  - Outputs stay 0 until the first clk edge after rst falls.
  - Reset mid-transfer discards any in-flight B result and all pending bits.
- Arbitration (combinational):
  - b_ready = !a_valid.
  - Port A always wins when valid, including while hold_a=1.
  - A B handshake is b_valid && b_ready.
- Writeback (registered, 1-cycle latency):
  - On each edge, wb_en <= winner valid && winner rd != 0.
  - wb_addr and wb_data load from the winner.
  - Internal flag wb_src_b <= winner is B.
  - A rd of x0 completes the handshake but produces no write.
- Starvation counter (saturates at STARVE_LIMIT):
  - Increments on every edge with b_valid && !b_ready.
  - Clears on a B handshake or when b_valid=0.
  - hold_a = (counter == STARVE_LIMIT). It is register-derived, so there is no combinational path from inputs.
- Scoreboard:
  - Set: on an edge with iss_valid and iss_rd != 0, sets bit iss_rd.
  - Clear: on an edge with wb_en && wb_src_b, clears bit wb_addr. The register file has been written by then, so the value is readable the cycle after the clear.
  - Set and clear of the same bit on the same edge: set wins.
- Stall (combinational from scoreboard):
  - stall = OR over dec_rs1, dec_rs2, dec_rd (each != 0) of its pending bit.
  - iss_valid must be low while stall=1.
- proto_err sets on any of:
  - a_valid while hold_a=1;
  - a_valid with a_rd pending;
  - iss_valid with iss_rd already pending;
  - a B handshake whose b_rd is not pending (and b_rd != 0).
- proto_err sets only. Reset is the only clear. The offending write still proceeds.

Optional Feature:
- Macro: RFWB_PERF_EN.
- Defined:
  - perf_b_wait increments on every edge with b_valid && !b_ready.
  - perf_stall increments on every edge with stall=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- B-only: iss_valid, iss_rd=5 at cycle 0; stall with dec_rs1=5 from cycle 1; b_valid, b_rd=5, b_data=0xDEADBEEF at cycle 3 -> b_ready=1, wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in cycle 4; pending[5]=0 and stall=0 in cycle 5.
- Collision: a_valid (a_rd=3, 0x11) and b_valid (b_rd=7) in the same cycle -> b_ready=0 and A writes x3 next cycle; B writes x7 in the first cycle a_valid=0.
- Starvation, STARVE_LIMIT=4: b_valid held with a_valid high cycles 0-3 -> hold_a=1 in cycle 4; core drops a_valid -> B handshakes in cycle 4, wb_en from B in cycle 5, hold_a=0 in cycle 5.
- x0 handling: a_valid with a_rd=0, and iss_rd=0 -> wb_en stays 0, pending stays 0, stall never asserts.
- Same-edge set and clear: B writeback to x9 committing on the edge where iss_rd=9 -> pending[9]=1 afterwards.
- Async reset mid-op: rst pulsed between clock edges while pending=0x0000_0020 and wb_en=1 -> all outputs 0 immediately; proto_err=0; perf counters 0 with RFWB_PERF_EN.
